// File: rtl/cdc_fifo_serial_tx_pkg.sv
// Shared types and constants for the CDC FIFO serial transmitter.
`timescale 1ns/1ps
package cdc_fifo_serial_tx_pkg;

    localparam int FRAME_COUNT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/cdc_fifo_serial_tx_if.sv
// Show-ahead FIFO read port as seen by its single reader.
`timescale 1ns/1ps
interface cdc_fifo_serial_tx_if #(
    parameter int DATA_WIDTH = 4
);

    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_read_data;
    logic                  fifo_read_increment;

    // master is the reader (transmitter), slave is the FIFO read port
    modport master (
        input  fifo_empty,
        input  fifo_read_data,
        output fifo_read_increment
    );

    modport slave (
        output fifo_empty,
        output fifo_read_data,
        input  fifo_read_increment
    );

endinterface

// File: rtl/cdc_fifo_serial_tx_bit_timer.sv
// Free-running bit-period counter; bit_end marks the last cycle of each bit.
`timescale 1ns/1ps
module bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // restart aligns the first bit of a frame to the cycle after the load edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (restart || (count == LAST_COUNT)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_end = (count == LAST_COUNT);

endmodule

// File: rtl/cdc_fifo_serial_tx.sv
// Drains a show-ahead FIFO read port and sends each word as an async serial frame.
`timescale 1ns/1ps
module cdc_fifo_serial_tx
    import cdc_fifo_serial_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    cdc_fifo_serial_tx_if.master         fifo,
    output logic                         tx,
    output logic                         busy,
    output logic [FRAME_COUNT_WIDTH-1:0] frame_count
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    tx_state_t                    state;
    tx_state_t                    state_next;
    logic [DATA_WIDTH-1:0]        shreg;
    logic [DATA_WIDTH-1:0]        shreg_next;
    logic                         parity_bit;
    logic                         parity_next;
    logic [IDX_W-1:0]             bit_index;
    logic [IDX_W-1:0]             bit_index_next;
    logic                         tx_next;
    logic                         busy_next;
    logic [FRAME_COUNT_WIDTH-1:0] frame_count_next;
    logic                         bit_end;
    logic                         frame_done;
    logic                         load;
    logic                         timer_restart;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock  (clock),
        .reset  (reset),
        .restart(timer_restart),
        .bit_end(bit_end)
    );

    // Loading in the last STOP cycle chains frames with no idle gap
    assign frame_done    = (state == STOP) && bit_end;
    assign load          = enable && !fifo.fifo_empty && ((state == IDLE) || frame_done);
    assign timer_restart = (state == IDLE) || load;

    assign fifo.fifo_read_increment = load && !reset;

    // tx and busy are computed from the next state so they register in step with it
    always_comb begin
        state_next       = state;
        shreg_next       = shreg;
        parity_next      = parity_bit;
        bit_index_next   = bit_index;
        frame_count_next = frame_count;

        case (state)
            IDLE: begin
                if (load) begin
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_next = shreg >> 1;
                    if (bit_index == LAST_IDX) begin
                        bit_index_next = '0;
                        state_next     = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_index_next = bit_index + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    frame_count_next = frame_count + 1'b1;
                    state_next       = load ? START : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load) begin
            shreg_next     = fifo.fifo_read_data;
            parity_next    = ^fifo.fifo_read_data;
            bit_index_next = '0;
        end

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = 1'b1;
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            parity_bit  <= 1'b0;
            bit_index   <= '0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_next;
            shreg       <= shreg_next;
            parity_bit  <= parity_next;
            bit_index   <= bit_index_next;
            tx          <= tx_next;
            busy        <= busy_next;
            frame_count <= frame_count_next;
        end
    end

endmodule

// File: tb/tb_cdc_fifo_serial_tx.sv
// Bench for cdc_fifo_serial_tx: FIFO read-port model plus a word scoreboard per DUT.
`timescale 1ns/1ps
module tb_cdc_fifo_serial_tx;

    localparam int DW     = 4;
    localparam int CPB    = 4;
    localparam int FRAME0 = (2 + DW) * CPB;
    localparam int FRAME1 = (3 + DW) * CPB;
    localparam int LOGN   = 128;

    logic          clock   = 1'b0;
    logic          reset   = 1'b1;
    logic          enable0 = 1'b0;
    logic          enable1 = 1'b0;
    logic          tx0, busy0, tx1, busy1;
    logic [7:0]    fc0, fc1;
    logic          fifo0_empty = 1'b1;
    logic          fifo1_empty = 1'b1;
    logic [DW-1:0] fifo0_data  = '0;
    logic [DW-1:0] fifo1_data  = '0;

    logic [DW-1:0] fifo0_q[$];
    logic [DW-1:0] fifo1_q[$];
    logic [DW-1:0] exp0_q[$];
    logic [DW-1:0] exp1_q[$];
    int            inc_count0 = 0;
    int            inc_count1 = 0;
    logic [7:0]    exp_fc0    = 8'd0;

    int errors = 0;
    int checks = 0;

    logic       tx_log  [0:LOGN-1];
    logic       busy_log[0:LOGN-1];
    logic       inc_log [0:LOGN-1];
    logic [7:0] fc_log  [0:LOGN-1];

    cdc_fifo_serial_tx_if #(.DATA_WIDTH(DW)) if0 ();
    cdc_fifo_serial_tx_if #(.DATA_WIDTH(DW)) if1 ();

    assign if0.fifo_empty     = fifo0_empty;
    assign if0.fifo_read_data = fifo0_data;
    assign if1.fifo_empty     = fifo1_empty;
    assign if1.fifo_read_data = fifo1_data;

    cdc_fifo_serial_tx #(
        .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)
    ) dut0 (
        .clock(clock), .reset(reset), .enable(enable0), .fifo(if0),
        .tx(tx0), .busy(busy0), .frame_count(fc0)
    );

    cdc_fifo_serial_tx #(
        .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)
    ) dut1 (
        .clock(clock), .reset(reset), .enable(enable1), .fifo(if1),
        .tx(tx1), .busy(busy1), .frame_count(fc1)
    );

    always #5 clock = ~clock;

    // Show-ahead FIFO models; flags update with NBAs so the DUT sees pre-edge values
    always @(posedge clock) begin
        if (if0.fifo_read_increment) begin
            inc_count0++;
            if (fifo0_q.size() > 0) void'(fifo0_q.pop_front());
        end
        if (if1.fifo_read_increment) begin
            inc_count1++;
            if (fifo1_q.size() > 0) void'(fifo1_q.pop_front());
        end
        fifo0_empty <= (fifo0_q.size() == 0);
        fifo0_data  <= (fifo0_q.size() > 0) ? fifo0_q[0] : '0;
        fifo1_empty <= (fifo1_q.size() == 0);
        fifo1_data  <= (fifo1_q.size() > 0) ? fifo1_q[0] : '0;
    end

    function automatic logic exp_tx(input logic [DW-1:0] w, input bit par_en, input int idx);
        int slot;
        slot = idx / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= DW) return w[slot-1];
        if (par_en && (slot == DW + 1)) return ^w;
        return 1'b1;
    endfunction

    task automatic wait_frame_start(input int sel, input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; (i < limit) && !found; i++) begin
            @(negedge clock);
            if (((sel != 0) ? tx1 : tx0) == 1'b0) found = 1'b1;
        end
    endtask

    task automatic capture(input int sel, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clock);
            tx_log[first+i]   = (sel != 0) ? tx1 : tx0;
            busy_log[first+i] = (sel != 0) ? busy1 : busy0;
            inc_log[first+i]  = (sel != 0) ? if1.fifo_read_increment : if0.fifo_read_increment;
            fc_log[first+i]   = (sel != 0) ? fc1 : fc0;
        end
    endtask

    task automatic test_reset();
        enable0 = 1'b1;
        fifo0_q.push_back(4'hA);
        exp0_q.push_back(4'hA);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checks++;
            if (tx0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx cyc%0d: got %b expected 1", c, tx0); end
            checks++;
            if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy cyc%0d: got %b expected 0", c, busy0); end
            checks++;
            if (if0.fifo_read_increment !== 1'b0) begin
                errors++; $display("[TB] FAIL reset_inc cyc%0d: got %b expected 0", c, if0.fifo_read_increment);
            end
            checks++;
            if (fc0 !== 8'd0) begin errors++; $display("[TB] FAIL reset_fc cyc%0d: got %0d expected 0", c, fc0); end
        end
    endtask

    task automatic test_single_word();
        bit            found;
        logic [DW-1:0] w;
        int            busy_cycles;
        reset = 1'b0;
        #1;
        checks++;
        if (if0.fifo_read_increment !== 1'b1) begin
            errors++; $display("[TB] FAIL single_inc_after_reset: got %b expected 1", if0.fifo_read_increment);
        end
        wait_frame_start(0, 10, found);
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL single_start: got timeout expected start bit"); end
        capture(0, 0, FRAME0 + 1);
        w = exp0_q.pop_front();
        exp_fc0++;
        busy_cycles = 0;
        for (int i = 0; i < FRAME0; i++) begin
            checks++;
            if (tx_log[i] !== exp_tx(w, 1'b0, i)) begin
                errors++; $display("[TB] FAIL single_tx[%0d]: got %b expected %b", i, tx_log[i], exp_tx(w, 1'b0, i));
            end
        end
        for (int i = 0; i <= FRAME0; i++) if (busy_log[i] === 1'b1) busy_cycles++;
        checks++;
        if (busy_cycles != FRAME0) begin errors++; $display("[TB] FAIL single_busy_len: got %0d expected %0d", busy_cycles, FRAME0); end
        checks++;
        if (busy_log[FRAME0] !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end: got %b expected 0", busy_log[FRAME0]); end
        checks++;
        if (fc_log[FRAME0] !== exp_fc0) begin errors++; $display("[TB] FAIL single_fc: got %0d expected %0d", fc_log[FRAME0], exp_fc0); end
        checks++;
        if (inc_count0 != 1) begin errors++; $display("[TB] FAIL single_pops: got %0d expected 1", inc_count0); end
    endtask

    task automatic test_back_to_back();
        bit            found;
        logic [DW-1:0] w1, w2;
        logic          e;
        int            n0;
        n0 = inc_count0;
        fifo0_q.push_back(4'h3); exp0_q.push_back(4'h3);
        fifo0_q.push_back(4'hC); exp0_q.push_back(4'hC);
        wait_frame_start(0, 20, found);
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL b2b_start: got timeout expected start bit"); end
        capture(0, 0, 2 * FRAME0 + 1);
        w1 = exp0_q.pop_front();
        w2 = exp0_q.pop_front();
        exp_fc0 += 8'd2;
        for (int i = 0; i < 2 * FRAME0; i++) begin
            e = (i < FRAME0) ? exp_tx(w1, 1'b0, i) : exp_tx(w2, 1'b0, i - FRAME0);
            checks++;
            if (tx_log[i] !== e) begin errors++; $display("[TB] FAIL b2b_tx[%0d]: got %b expected %b", i, tx_log[i], e); end
            checks++;
            if (busy_log[i] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy[%0d]: got %b expected 1", i, busy_log[i]); end
            checks++;
            if (inc_log[i] !== (i == FRAME0 - 1)) begin
                errors++; $display("[TB] FAIL b2b_inc[%0d]: got %b expected %b", i, inc_log[i], (i == FRAME0 - 1));
            end
        end
        checks++;
        if (busy_log[2*FRAME0] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_end: got %b expected 0", busy_log[2*FRAME0]); end
        checks++;
        if (fc_log[2*FRAME0] !== exp_fc0) begin errors++; $display("[TB] FAIL b2b_fc: got %0d expected %0d", fc_log[2*FRAME0], exp_fc0); end
        checks++;
        if (inc_count0 - n0 != 2) begin errors++; $display("[TB] FAIL b2b_pops: got %0d expected 2", inc_count0 - n0); end
    endtask

    task automatic test_parity();
        bit            found;
        logic [DW-1:0] w;
        int            busy_cycles;
        enable1 = 1'b1;
        fifo1_q.push_back(4'h7);
        exp1_q.push_back(4'h7);
        wait_frame_start(1, 20, found);
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL parity_start: got timeout expected start bit"); end
        capture(1, 0, FRAME1 + 1);
        enable1 = 1'b0;
        w = exp1_q.pop_front();
        for (int i = 0; i < FRAME1; i++) begin
            checks++;
            if (tx_log[i] !== exp_tx(w, 1'b1, i)) begin
                errors++; $display("[TB] FAIL parity_tx[%0d]: got %b expected %b", i, tx_log[i], exp_tx(w, 1'b1, i));
            end
        end
        busy_cycles = 0;
        for (int i = 0; i <= FRAME1; i++) if (busy_log[i] === 1'b1) busy_cycles++;
        checks++;
        if (busy_cycles != FRAME1) begin errors++; $display("[TB] FAIL parity_len: got %0d expected %0d", busy_cycles, FRAME1); end
        checks++;
        if (fc_log[FRAME1] !== 8'd1) begin errors++; $display("[TB] FAIL parity_fc: got %0d expected 1", fc_log[FRAME1]); end
        checks++;
        if (inc_count1 != 1) begin errors++; $display("[TB] FAIL parity_pops: got %0d expected 1", inc_count1); end
    endtask

    task automatic test_enable_drop();
        bit            found;
        logic [DW-1:0] w;
        int            n_after;
        fifo0_q.push_back(4'h1); exp0_q.push_back(4'h1);
        fifo0_q.push_back(4'h4); exp0_q.push_back(4'h4);
        fifo0_q.push_back(4'h2); exp0_q.push_back(4'h2);
        wait_frame_start(0, 20, found);
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL endrop_start: got timeout expected start bit"); end
        n_after = inc_count0;
        capture(0, 0, 7);
        enable0 = 1'b0;
        @(negedge clock);
        capture(0, 7, FRAME0 + 1 - 7);
        w = exp0_q.pop_front();
        exp_fc0++;
        for (int i = 0; i < FRAME0; i++) begin
            checks++;
            if (tx_log[i] !== exp_tx(w, 1'b0, i)) begin
                errors++; $display("[TB] FAIL endrop_tx[%0d]: got %b expected %b", i, tx_log[i], exp_tx(w, 1'b0, i));
            end
        end
        checks++;
        if (fc_log[FRAME0] !== exp_fc0) begin errors++; $display("[TB] FAIL endrop_fc: got %0d expected %0d", fc_log[FRAME0], exp_fc0); end
        repeat (30) @(negedge clock);
        checks++;
        if (inc_count0 != n_after) begin errors++; $display("[TB] FAIL endrop_pops: got %0d expected %0d", inc_count0, n_after); end
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL endrop_idle_busy: got %b expected 0", busy0); end
        checks++;
        if (fifo0_q.size() != 2) begin errors++; $display("[TB] FAIL endrop_fifo_left: got %0d expected 2", fifo0_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        bit            found;
        logic [DW-1:0] w;
        enable0 = 1'b1;
        wait_frame_start(0, 20, found);
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL midrst_start: got timeout expected start bit"); end
        void'(exp0_q.pop_front());
        capture(0, 0, 10);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (tx0 !== 1'b1) begin errors++; $display("[TB] FAIL midrst_tx_async: got %b expected 1", tx0); end
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy_async: got %b expected 0", busy0); end
        checks++;
        if (fc0 !== 8'd0) begin errors++; $display("[TB] FAIL midrst_fc_async: got %0d expected 0", fc0); end
        checks++;
        if (if0.fifo_read_increment !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_inc: got %b expected 0", if0.fifo_read_increment);
        end
        exp_fc0 = 8'd0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (if0.fifo_read_increment !== 1'b1) begin
            errors++; $display("[TB] FAIL midrst_fresh_pop: got %b expected 1", if0.fifo_read_increment);
        end
        wait_frame_start(0, 10, found);
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL midrst_restart: got timeout expected start bit"); end
        capture(0, 0, FRAME0 + 1);
        w = exp0_q.pop_front();
        exp_fc0++;
        for (int i = 0; i < FRAME0; i++) begin
            checks++;
            if (tx_log[i] !== exp_tx(w, 1'b0, i)) begin
                errors++; $display("[TB] FAIL midrst_tx[%0d]: got %b expected %b", i, tx_log[i], exp_tx(w, 1'b0, i));
            end
        end
        checks++;
        if (fc_log[FRAME0] !== exp_fc0) begin errors++; $display("[TB] FAIL midrst_fc: got %0d expected %0d", fc_log[FRAME0], exp_fc0); end
        checks++;
        if (fifo0_q.size() != 0) begin errors++; $display("[TB] FAIL midrst_fifo_left: got %0d expected 0", fifo0_q.size()); end
    endtask

    task automatic test_frame_count_wrap();
        bit            found;
        logic [DW-1:0] w, got;
        int            nframes;
        nframes = 256 - int'(exp_fc0);
        for (int k = 0; k < nframes; k++) begin
            w = DW'($urandom_range(0, (1 << DW) - 1));
            fifo0_q.push_back(w);
            exp0_q.push_back(w);
        end
        for (int k = 0; k < nframes; k++) begin
            wait_frame_start(0, 2 * FRAME0, found);
            checks++;
            if (!found) begin errors++; $display("[TB] FAIL wrap_start frame%0d: got timeout expected start bit", k); break; end
            capture(0, 0, FRAME0);
            w = exp0_q.pop_front();
            for (int b = 0; b < DW; b++) got[b] = tx_log[CPB * (b + 1) + CPB / 2];
            checks++;
            if ((got !== w) || (tx_log[FRAME0-1] !== 1'b1)) begin
                errors++; $display("[TB] FAIL wrap_word frame%0d: got %h stop=%b expected %h stop=1", k, got, tx_log[FRAME0-1], w);
            end
            if (k == nframes - 1) begin
                checks++;
                if (fc_log[FRAME0-1] !== 8'd255) begin errors++; $display("[TB] FAIL wrap_fc_last: got %0d expected 255", fc_log[FRAME0-1]); end
            end
            exp_fc0++;
        end
        @(negedge clock);
        checks++;
        if (fc0 !== exp_fc0) begin errors++; $display("[TB] FAIL wrap_fc: got %0d expected %0d", fc0, exp_fc0); end
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL wrap_busy_end: got %b expected 0", busy0); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_parity();
        test_enable_drop();
        test_reset_mid_frame();
        test_frame_count_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cdc_fifo_serial_tx.md
# cdc_fifo_serial_tx

Read-side consumer for the CDC FIFO. It runs in the FIFO's read-clock domain, drains the FIFO's show-ahead read port one word at a time, and transmits each word as an asynchronous serial frame on `tx`: start bit, data LSB first, optional even parity, stop bit. It is the transmitting end paired with the FIFO's read port and is the FIFO's only reader.

## Interface
Parameters:
- `DATA_WIDTH`, 4: word width; must equal the FIFO data width.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; ≥2.
- `PARITY_EN`, 0: 1 inserts an even-parity bit after the data bits.

Ports:
- `clock`  in  1  clock, tied to the FIFO read clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  permits starting new frames.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_read_data`  in  DATA_WIDTH  FIFO head word; valid whenever `fifo_empty`=0.
- `fifo_read_increment`  out  1  one-cycle pop strobe to the FIFO.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is on the line.
- `frame_count`  out  8  number of completed frames; wraps.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Load condition: `enable` & !`fifo_empty` & (state==IDLE, or state==STOP in its final cycle).
- `fifo_read_increment` is combinational and equals the load condition. It is forced to 0 while `reset` is high.
- On load:
  - capture `fifo_read_data` into the shift register;
  - compute parity as the XOR of the captured data bits;
  - go to START on the next edge.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `tx`=shreg[0] for CLKS_PER_BIT cycles per bit; shift right at each bit end. After DATA_WIDTH bits, go to PARITY if PARITY_EN, else STOP.
- PARITY: `tx`=parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles.
  - On the final STOP cycle, `frame_count` increments.
  - If the load condition holds on that cycle, go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- `busy`=1 in START, DATA, PARITY and STOP; 0 in IDLE.
- `enable` deasserted mid-frame: the current frame completes; no further loads.
- `fifo_empty` rising mid-frame: no effect on the current frame.
- Reset:
  - `tx`=1, `busy`=0, `fifo_read_increment`=0, `frame_count`=0, state=IDLE;
  - internal counters and shift register are cleared.
  - Reset mid-frame aborts the frame immediately; the popped word is lost.
  - The FIFO read pointer is not touched by this block.

## Timing
- `tx`, `busy` and `frame_count` are registered outputs.
- Frame length = (2 + DATA_WIDTH + PARITY_EN) × CLKS_PER_BIT cycles.
- The first START cycle is the cycle after the load edge.
- Bit timer counts 0..CLKS_PER_BIT-1; width $clog2(CLKS_PER_BIT). Bit index width $clog2(DATA_WIDTH).
- `frame_count` is 8-bit modulo 256 (255→0).
- At most one pop per frame. `fifo_read_increment` is never high on two consecutive cycles.

## Structure
- Package `cdc_fifo_serial_tx_pkg`: the `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP) and the `FRAME_COUNT_WIDTH`=8 constant.
- One sub-module, `bit_timer`: a CLKS_PER_BIT-cycle counter with `restart` input and `bit_end` pulse output, using the same clock and reset.
- The top level holds the FSM, shift register, parity and frame counter.

## Test plan
All scenarios use DATA_WIDTH=4 and CLKS_PER_BIT=4 unless stated.
- Reset with `enable`=1 and `fifo_empty`=0 held → `tx`=1, `busy`=0, `fifo_read_increment`=0, `frame_count`=0 throughout reset.
- Single word 0xA, then FIFO goes empty → one increment pulse; `tx`=0,0,1,0,1,1 (start, LSB-first data, stop), 4 cycles each; `busy` high for 24 cycles; then `frame_count`=1.
- Words 0x3 then 0xC queued → second pop in the last STOP cycle of frame 1; `tx` carries 48 contiguous cycles with no idle gap; `frame_count`=2.
- PARITY_EN=1, word 0x7 → `tx`=0,1,1,1,0,1,1; frame is 28 cycles long.
- `enable` dropped during DATA with FIFO non-empty → current frame completes; no further increments while `enable`=0. With 256 frames sent, `frame_count` reads 0.
- `reset` asserted during the second DATA bit → `tx`=1 and `busy`=0 asynchronously. After release, the next frame starts from IDLE with a fresh pop; `frame_count` restarts from 0.
